// File: rtl/hydra_remap_pkg.sv
// hydra_remap_pkg: shared types, constants and window-match helper for the AXI address remapper.
package hydra_remap_pkg;

    localparam int MAX_WIN = 4;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_err_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_SINK, B_RESP} wr_err_e;

    // Windows are zero-extended into 64-bit lanes so one helper serves every parameterisation.
    function automatic logic [MAX_WIN-1:0] win_hit(
        input logic [63:0]           addr,
        input logic [MAX_WIN*64-1:0] base,
        input logic [MAX_WIN*64-1:0] mask,
        input int                    num
    );
        logic [MAX_WIN-1:0] h;
        for (int i = 0; i < MAX_WIN; i++)
            h[i] = (i < num) && ((addr & mask[i*64 +: 64]) == base[i*64 +: 64]);
        return h;
    endfunction

endpackage

// File: rtl/hydra_remap_dec.sv
// hydra_remap_dec: combinational window decoder; lowest-index hit supplies the translated address.
module hydra_remap_dec
    import hydra_remap_pkg::*;
#(
    parameter int ADDR_W_IN  = 64,
    parameter int ADDR_W_OUT = 32,
    parameter int NUM_WIN    = 1,
    parameter logic [NUM_WIN*ADDR_W_IN-1:0] WIN_BASE = {NUM_WIN{64'h0}},
    parameter logic [NUM_WIN*ADDR_W_IN-1:0] WIN_MASK = {NUM_WIN{64'hFFFF_FFFF_0000_0000}},
    parameter logic [NUM_WIN*ADDR_W_IN-1:0] WIN_TGT  = {NUM_WIN{64'h0}}
) (
    input  logic [ADDR_W_IN-1:0]  addr,
    output logic                  hit,
    output logic [ADDR_W_OUT-1:0] out_addr
);

    logic [MAX_WIN*64-1:0] base_w;
    logic [MAX_WIN*64-1:0] mask_w;
    logic [MAX_WIN-1:0]    hv;

    always_comb begin
        base_w = '0;
        mask_w = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            base_w[i*64 +: 64] = 64'(WIN_BASE[i*ADDR_W_IN +: ADDR_W_IN]);
            mask_w[i*64 +: 64] = 64'(WIN_MASK[i*ADDR_W_IN +: ADDR_W_IN]);
        end
        hv = win_hit(64'(addr), base_w, mask_w, NUM_WIN);
        hit = |hv;
        out_addr = '0;
        // Walk downward so the lowest matching window is applied last and wins.
        for (int i = NUM_WIN - 1; i >= 0; i--)
            if (hv[i])
                out_addr = ADDR_W_OUT'(WIN_TGT[i*ADDR_W_IN +: ADDR_W_IN] | (addr & ~WIN_MASK[i*ADDR_W_IN +: ADDR_W_IN]));
    end

endmodule

// File: rtl/hydra_axi_addr_remap.sv
// hydra_axi_addr_remap: AXI4 window remapper; unmapped accesses get local DECERR responses.
// Error logging outputs are live only when HYDRA_REMAP_ERR_LOG_EN is defined.
module hydra_axi_addr_remap
    import hydra_remap_pkg::*;
#(
    parameter int ADDR_W_IN  = 64,
    parameter int ADDR_W_OUT = 32,
    parameter int DATA_W     = 64,
    parameter int ID_W       = 5,
    parameter int NUM_WIN    = 1,
    parameter logic [NUM_WIN*ADDR_W_IN-1:0] WIN_BASE = {NUM_WIN{64'h0}},
    parameter logic [NUM_WIN*ADDR_W_IN-1:0] WIN_MASK = {NUM_WIN{64'hFFFF_FFFF_0000_0000}},
    parameter logic [NUM_WIN*ADDR_W_IN-1:0] WIN_TGT  = {NUM_WIN{64'h0}},
    parameter int MAX_OUT    = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ID_W-1:0]       s_arid,
    input  logic [ADDR_W_IN-1:0]  s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arlock,
    input  logic [3:0]            s_arcache,
    input  logic [2:0]            s_arprot,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ID_W-1:0]       s_awid,
    input  logic [ADDR_W_IN-1:0]  s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awlock,
    input  logic [3:0]            s_awcache,
    input  logic [2:0]            s_awprot,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [ID_W-1:0]       s_rid,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [ID_W-1:0]       s_bid,
    output logic [1:0]            s_bresp,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ID_W-1:0]       m_arid,
    output logic [ADDR_W_OUT-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arlock,
    output logic [3:0]            m_arcache,
    output logic [2:0]            m_arprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ID_W-1:0]       m_awid,
    output logic [ADDR_W_OUT-1:0] m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awlock,
    output logic [3:0]            m_awcache,
    output logic [2:0]            m_awprot,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [ID_W-1:0]       m_rid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [ID_W-1:0]       m_bid,
    input  logic [1:0]            m_bresp,
    output logic                  err_val,
    output logic [ADDR_W_IN-1:0]  err_addr,
    output logic [15:0]           err_cnt
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    rd_err_e rd_st, rd_nx;
    wr_err_e wr_st, wr_nx;
    logic [CW-1:0] rd_cnt, wr_cnt, wd_cnt;
    logic [ID_W-1:0] rid_q, wid_q;
    logic [7:0] rlen_q, rbeat;
    logic ar_hit, aw_hit, rd_go, wr_go, ar_err, aw_err, ar_fwd, aw_fwd;
    logic r_err, b_err, w_sink, w_blk, r_done, b_done, w_done;

    hydra_remap_dec #(.ADDR_W_IN(ADDR_W_IN), .ADDR_W_OUT(ADDR_W_OUT), .NUM_WIN(NUM_WIN),
        .WIN_BASE(WIN_BASE), .WIN_MASK(WIN_MASK), .WIN_TGT(WIN_TGT))
        u_ar_dec (.addr(s_araddr), .hit(ar_hit), .out_addr(m_araddr));

    hydra_remap_dec #(.ADDR_W_IN(ADDR_W_IN), .ADDR_W_OUT(ADDR_W_OUT), .NUM_WIN(NUM_WIN),
        .WIN_BASE(WIN_BASE), .WIN_MASK(WIN_MASK), .WIN_TGT(WIN_TGT))
        u_aw_dec (.addr(s_awaddr), .hit(aw_hit), .out_addr(m_awaddr));

    assign rd_go     = (rd_st == R_IDLE) && (rd_cnt != CNT_MAX);
    assign wr_go     = (wr_st == W_IDLE) && (wr_cnt != CNT_MAX);
    assign m_arvalid = s_arvalid & ar_hit & rd_go;
    assign m_awvalid = s_awvalid & aw_hit & wr_go;
    assign s_arready = rd_go & (ar_hit ? m_arready : 1'b1);
    assign s_awready = wr_go & (aw_hit ? m_awready : 1'b1);
    assign ar_fwd    = m_arvalid & m_arready;
    assign aw_fwd    = m_awvalid & m_awready;
    assign ar_err    = s_arvalid & ~ar_hit & rd_go;
    assign aw_err    = s_awvalid & ~aw_hit & wr_go;

    assign {m_arid, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot} =
           {s_arid, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot};
    assign {m_awid, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot} =
           {s_awid, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot};

    // While waiting, W beats still owed by earlier forwarded writes pass; the faulting burst is held back.
    assign w_sink   = wr_st == W_SINK;
    assign w_blk    = (wr_st == W_WAIT) && (wd_cnt == '0);
    assign m_wvalid = s_wvalid & ~w_sink & ~w_blk;
    assign s_wready = w_sink | (~w_blk & m_wready);
    assign {m_wdata, m_wstrb, m_wlast} = {s_wdata, s_wstrb, s_wlast};

    assign r_err    = rd_st == R_RESP;
    assign s_rvalid = r_err | m_rvalid;
    assign s_rid    = r_err ? rid_q : m_rid;
    assign s_rdata  = r_err ? '0 : m_rdata;
    assign s_rresp  = r_err ? AXI_RESP_DECERR : m_rresp;
    assign s_rlast  = r_err ? (rbeat == rlen_q) : m_rlast;
    assign m_rready = ~r_err & s_rready;

    assign b_err    = wr_st == B_RESP;
    assign s_bvalid = b_err | m_bvalid;
    assign s_bid    = b_err ? wid_q : m_bid;
    assign s_bresp  = b_err ? AXI_RESP_DECERR : m_bresp;
    assign m_bready = ~b_err & s_bready;

    assign r_done = m_rvalid & m_rready & m_rlast;
    assign b_done = m_bvalid & m_bready;
    assign w_done = m_wvalid & m_wready & s_wlast;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_st  <= R_IDLE;
            wr_st  <= W_IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
            wd_cnt <= '0;
        end else begin
            rd_st  <= rd_nx;
            wr_st  <= wr_nx;
            rd_cnt <= rd_cnt + CW'(ar_fwd) - CW'(r_done);
            wr_cnt <= wr_cnt + CW'(aw_fwd) - CW'(b_done);
            wd_cnt <= wd_cnt + CW'(aw_fwd) - CW'(w_done);
        end
    end

    always_comb begin
        rd_nx = rd_st;
        wr_nx = wr_st;
        rd_nx = rd_st == R_IDLE ? (ar_err ? (rd_cnt == '0 ? R_RESP : R_WAIT) : R_IDLE)
              : rd_st == R_WAIT ? (rd_cnt == '0 ? R_RESP : R_WAIT)
              : (s_rready && rbeat == rlen_q ? R_IDLE : R_RESP);
        wr_nx = wr_st == W_IDLE ? (aw_err ? (wr_cnt == '0 ? W_SINK : W_WAIT) : W_IDLE)
              : wr_st == W_WAIT ? (wr_cnt == '0 ? W_SINK : W_WAIT)
              : wr_st == W_SINK ? (s_wvalid && s_wlast ? B_RESP : W_SINK)
              : (s_bready ? W_IDLE : B_RESP);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rid_q  <= '0;
            wid_q  <= '0;
            rlen_q <= '0;
            rbeat  <= '0;
        end else begin
            if (ar_err) begin
                rid_q  <= s_arid;
                rlen_q <= s_arlen;
                rbeat  <= '0;
            end else if (r_err && s_rready) begin
                rbeat <= rbeat + 8'd1;
            end
            if (aw_err)
                wid_q <= s_awid;
        end
    end

`ifdef HYDRA_REMAP_ERR_LOG_EN
    logic [16:0] cnt_sum;
    assign cnt_sum = {1'b0, err_cnt} + 17'(ar_err) + 17'(aw_err);

    // A simultaneous AR and AW fault logs the AR address and counts twice.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_val  <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            err_val <= err_val | ar_err | aw_err;
            if (!err_val && (ar_err || aw_err))
                err_addr <= ar_err ? s_araddr : s_awaddr;
            err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end
`else
    assign err_val  = 1'b0;
    assign err_addr = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_hydra_axi_addr_remap.sv
// tb_hydra_axi_addr_remap: randomized scoreboard bench for the AXI window remapper.
module tb_hydra_axi_addr_remap;

`ifdef HYDRA_REMAP_ERR_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    localparam logic [63:0] WB [2] = '{64'h0, 64'h1_0000_0000};
    localparam logic [63:0] WM [2] = '{64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_F000_0000};
    localparam logic [63:0] WT [2] = '{64'h0, 64'h4000_0000};

    logic clk = 1'b0, arst_n = 1'b0;
    logic s_arvalid = 0, s_arready, s_arlock = 0, s_awvalid = 0, s_awready, s_awlock = 0;
    logic [4:0] s_arid = 0, s_awid = 0, s_rid, s_bid, m_arid, m_awid, m_rid = 0, m_bid = 0;
    logic [63:0] s_araddr = 0, s_awaddr = 0, s_wdata = 0, s_rdata, m_wdata, m_rdata = 0, err_addr;
    logic [7:0] s_arlen = 0, s_awlen = 0, s_wstrb = 0, m_arlen, m_awlen, m_wstrb;
    logic [2:0] s_arsize = 0, s_awsize = 0, s_arprot = 0, s_awprot = 0, m_arsize, m_awsize, m_arprot, m_awprot;
    logic [1:0] s_arburst = 0, s_awburst = 0, s_rresp, s_bresp, m_arburst, m_awburst, m_rresp = 0, m_bresp = 0;
    logic [3:0] s_arcache = 0, s_awcache = 0, m_arcache, m_awcache;
    logic s_wvalid = 0, s_wready, s_wlast = 0, s_rvalid, s_rready = 0, s_rlast, s_bvalid, s_bready = 0;
    logic m_arvalid, m_arready = 0, m_arlock, m_awvalid, m_awready = 0, m_awlock;
    logic m_wvalid, m_wready = 0, m_wlast, m_rvalid = 0, m_rready, m_rlast = 0, m_bvalid = 0, m_bready;
    logic [31:0] m_araddr, m_awaddr;
    logic err_val;
    logic [15:0] err_cnt;

    int total = 0, bad = 0;
    logic [127:0] q_ar[$], q_aw[$], q_w[$], q_r[$], q_b[$];
    bit ev = 0;
    logic [63:0] ea = '0;
    logic [15:0] ec = '0;

    always #5 clk = ~clk;

    hydra_axi_addr_remap #(
        .NUM_WIN(2),
        .WIN_BASE({64'h1_0000_0000, 64'h0}),
        .WIN_MASK({64'hFFFF_FFFF_F000_0000, 64'hFFFF_FFFF_0000_0000}),
        .WIN_TGT({64'h4000_0000, 64'h0})
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .err_val(err_val), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference decode: first window whose masked address equals its base.
    function automatic bit xlate(input logic [63:0] a, output logic [31:0] o);
        logic [63:0] t;
        o = '0;
        for (int i = 0; i < 2; i++)
            if ((a & WM[i]) == WB[i]) begin
                t = WT[i] | (a & ~WM[i]);
                o = t[31:0];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic logic [63:0] rnd_addr(input int kind);
        case (kind)
            0: return {32'h0, 32'($urandom)};
            1: return {32'h1, 4'h0, 28'($urandom)};
            2: return {32'($urandom_range(32'hFFFF_FFFF, 2)), 32'($urandom)};
            default: return {32'h1, 4'($urandom_range(15, 1)), 28'($urandom)};
        endcase
    endfunction

    task automatic log_err(input logic [63:0] a);
        if (!ev) begin ev = 1; ea = a; end
        if (ec != 16'hFFFF) ec++;
    endtask

    task automatic chk_log();
        chk("err_val", 128'(err_val), 128'(LOG ? ev : 1'b0));
        chk("err_addr", 128'(err_addr), 128'(LOG ? ea : 64'h0));
        chk("err_cnt", 128'(err_cnt), 128'(LOG ? ec : 16'h0));
    endtask

    always @(negedge clk) if (arst_n) begin
        logic [127:0] e;
        if (m_arvalid && m_arready) begin
            e = q_ar.size() ? q_ar.pop_front() : 'x;
            chk("m_ar", 128'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot}), e);
        end
        if (m_awvalid && m_awready) begin
            e = q_aw.size() ? q_aw.pop_front() : 'x;
            chk("m_aw", 128'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot}), e);
        end
        if (m_wvalid && m_wready) begin
            e = q_w.size() ? q_w.pop_front() : 'x;
            chk("m_w", 128'({m_wdata, m_wstrb, m_wlast}), e);
        end
        if (s_rvalid && s_rready) begin
            e = q_r.size() ? q_r.pop_front() : 'x;
            chk("s_r", 128'({s_rid, s_rdata, s_rresp, s_rlast}), e);
        end
        if (s_bvalid && s_bready) begin
            e = q_b.size() ? q_b.pop_front() : 'x;
            chk("s_b", 128'({s_bid, s_bresp}), e);
        end
    end

    task automatic ar_hs(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        logic [31:0] o;
        int n = 0;
        s_arid = id; s_araddr = a; s_arlen = len;
        s_arsize = 3'($urandom); s_arburst = 2'($urandom); s_arlock = 1'($urandom);
        s_arcache = 4'($urandom); s_arprot = 3'($urandom);
        if (xlate(a, o))
            q_ar.push_back(128'({id, o, len, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot}));
        else
            for (int i = 0; i <= int'(len); i++) q_r.push_back(128'({id, 64'h0, 2'b11, i == int'(len)}));
        s_arvalid = 1;
        do begin @(negedge clk); n++; end while (!s_arready && n < 200);
        if (!s_arready) chk("ar_timeout", 0, 1);
        @(posedge clk); #1 s_arvalid = 0;
    endtask

    task automatic aw_hs(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        logic [31:0] o;
        int n = 0;
        s_awid = id; s_awaddr = a; s_awlen = len;
        s_awsize = 3'($urandom); s_awburst = 2'($urandom); s_awlock = 1'($urandom);
        s_awcache = 4'($urandom); s_awprot = 3'($urandom);
        if (xlate(a, o))
            q_aw.push_back(128'({id, o, len, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot}));
        s_awvalid = 1;
        do begin @(negedge clk); n++; end while (!s_awready && n < 200);
        if (!s_awready) chk("aw_timeout", 0, 1);
        @(posedge clk); #1 s_awvalid = 0;
    endtask

    task automatic w_send(input bit last, input bit sunk);
        int n = 0;
        s_wdata = {$urandom, $urandom}; s_wstrb = 8'($urandom); s_wlast = last;
        if (!sunk) q_w.push_back(128'({s_wdata, s_wstrb, last}));
        s_wvalid = 1;
        do begin @(negedge clk); n++; end while (!s_wready && n < 200);
        if (!s_wready) chk("w_timeout", 0, 1);
        @(posedge clk); #1 s_wvalid = 0;
    endtask

    task automatic m_r_send(input logic [4:0] id, input bit last);
        int n = 0;
        m_rid = id; m_rdata = {$urandom, $urandom}; m_rresp = 2'($urandom_range(1, 0)); m_rlast = last;
        q_r.push_back(128'({id, m_rdata, m_rresp, last}));
        m_rvalid = 1;
        do begin @(negedge clk); n++; end while (!m_rready && n < 200);
        if (!m_rready) chk("r_timeout", 0, 1);
        @(posedge clk); #1 m_rvalid = 0;
    endtask

    task automatic m_b_send(input logic [4:0] id);
        int n = 0;
        m_bid = id; m_bresp = 2'b00;
        q_b.push_back(128'({id, 2'b00}));
        m_bvalid = 1;
        do begin @(negedge clk); n++; end while (!m_bready && n < 200);
        if (!m_bready) chk("b_timeout", 0, 1);
        @(posedge clk); #1 m_bvalid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_ar.size() + q_aw.size() + q_w.size() + q_r.size() + q_b.size()) != 0 && n < 300) begin
            @(negedge clk); n++;
        end
        chk("drain", 128'(q_ar.size() + q_aw.size() + q_w.size() + q_r.size() + q_b.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic rd_map(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        ar_hs(id, a, len);
        for (int i = 0; i <= int'(len); i++) m_r_send(id, i == int'(len));
        drain();
    endtask

    task automatic wr_map(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        aw_hs(id, a, len);
        for (int i = 0; i <= int'(len); i++) w_send(i == int'(len), 0);
        m_b_send(id);
        drain();
    endtask

    task automatic rd_err(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        ar_hs(id, a, len);
        log_err(a);
        drain();
    endtask

    task automatic wr_err(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len);
        aw_hs(id, a, len);
        log_err(a);
        for (int i = 0; i <= int'(len); i++) w_send(i == int'(len), 1);
        q_b.push_back(128'({id, 2'b11}));
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ids [8];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 128'(s_rvalid), 0);
        chk("rst_bvalid", 128'(s_bvalid), 0);
        chk("rst_wready", 128'(s_wready), 0);
        chk("rst_arvalid", 128'({m_arvalid, m_awvalid}), 0);
        chk_log();
        arst_n = 1;
        s_rready = 1; s_bready = 1; m_arready = 1; m_awready = 1; m_wready = 1;
        @(posedge clk); #1;

        rd_map(5'd3, 64'h0000_0000_8000_1000, 8'd1);
        wr_map(5'd4, 64'h1_0000_0040, 8'd2);
        rd_map(5'd6, 64'h0000_0000_FFFF_FFFC, 8'd0);
        wr_map(5'd8, 64'h1_0FFF_FFF8, 8'd0);

        rd_err(5'd5, 64'hF_0000_0000, 8'd3);
        chk_log();

        // Faulting write behind two forwarded writes: its DECERR must follow both OKAYs.
        aw_hs(5'd1, 64'h0000_0000_1234_0000, 8'd0);
        w_send(1, 0);
        aw_hs(5'd2, 64'h1_0000_1000, 8'd0);
        w_send(1, 0);
        aw_hs(5'd7, 64'h1_1000_0000, 8'd1);
        log_err(64'h1_1000_0000);
        repeat (3) begin @(negedge clk); chk("b_held", 128'(s_bvalid), 0); end
        @(posedge clk); #1;
        m_b_send(5'd1);
        m_b_send(5'd2);
        q_b.push_back(128'({5'd7, 2'b11}));
        w_send(0, 1);
        w_send(1, 1);
        drain();
        chk_log();

        for (int i = 0; i < 8; i++) begin
            ids[i] = 5'($urandom);
            ar_hs(ids[i], rnd_addr(i % 2), 8'd0);
        end
        s_araddr = 64'h0000_0000_0000_0100; s_arvalid = 1;
        repeat (3) begin @(negedge clk); chk("max_out_stall", 128'(s_arready), 0); end
        @(posedge clk); #1 s_arvalid = 0;
        for (int i = 0; i < 8; i++) m_r_send(ids[i], 1);
        drain();

        for (int k = 0; k < 24; k++) begin
            int kind = $urandom_range(3, 0);
            logic [4:0] id = 5'($urandom);
            logic [7:0] len = 8'($urandom_range(3, 0));
            logic [63:0] a = rnd_addr(kind);
            if ($urandom_range(1, 0) == 0)
                if (kind < 2) rd_map(id, a, len); else rd_err(id, a, len);
            else
                if (kind < 2) wr_map(id, a, len); else wr_err(id, a, len);
        end
        chk_log();

        ar_hs(5'd9, 64'h20_0000_0000, 8'd7);
        begin
            int n = 0;
            while (q_r.size() > 5 && n < 50) begin @(posedge clk); #1; n++; end
        end
        chk("mid_burst_rvalid", 128'(s_rvalid), 1);
        arst_n = 0;
        #1;
        chk("rst_mid_rvalid", 128'(s_rvalid), 0);
        q_r.delete();
        ev = 0; ea = '0; ec = '0;
        chk_log();
        @(posedge clk); #1 arst_n = 1;
        @(posedge clk); #1;

        fork
            ar_hs(5'd10, 64'hA_0000_0000, 8'd0);
            aw_hs(5'd11, 64'hB_0000_0000, 8'd0);
        join
        log_err(64'hA_0000_0000);
        log_err(64'hB_0000_0000);
        chk_log();
        w_send(1, 1);
        q_b.push_back(128'({5'd11, 2'b11}));
        drain();

        rd_map(5'd12, 64'h0000_0000_0000_0040, 8'd2);
        chk_log();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hydra_axi_addr_remap.md
# hydra_axi_addr_remap

- AXI4 address-window remapper between the hydra core AXI master port and the subsystem interconnect.
- Generalises the fixed 64→32-bit address mask into parametrised windows with per-window base, mask and target.
- Inbound addresses that hit no window are terminated locally with AXI DECERR responses, so they never reach the interconnect.
- Sits between `hydra_su` `maxi_*` and the interconnect `hydra_m_*` slave port.

## Interface
Parameters:
- `ADDR_W_IN`, 64, inbound address width
- `ADDR_W_OUT`, 32, outbound address width
- `DATA_W`, 64, data width; strobe width is `DATA_W/8`
- `ID_W`, 5, AXI ID width
- `NUM_WIN`, 1, number of windows, 1..4
- `WIN_BASE`, `{NUM_WIN{64'h0}}`, packed `NUM_WIN*ADDR_W_IN` match bases
- `WIN_MASK`, `{NUM_WIN{64'hFFFF_FFFF_0000_0000}}`, packed match masks
- `WIN_TGT`, `{NUM_WIN{64'h0}}`, packed target bases
- `MAX_OUT`, 8, maximum forwarded transactions outstanding per direction

Ports:
- `clk` in 1: single clock.
- `arst_n` in 1: asynchronous active-low reset.
- `s_ar*`, `s_aw*`, `s_w*`, `s_r*`, `s_b*` (slave side, from core): full AXI4 channel sets: valid, ready, id, addr (`ADDR_W_IN`), len, size, burst, lock, cache, prot, data, strb, last, resp.
- `m_ar*`, `m_aw*`, `m_w*`, `m_r*`, `m_b*` (master side): same channel sets; addr is `ADDR_W_OUT`.
- `err_val` out 1: sticky flag, set by any unmapped access.
- `err_addr` out `ADDR_W_IN`: address of the first unmapped access.
- `err_cnt` out 16: count of unmapped accesses, saturating.

## Operation
- Decode:
  - Window i hits when `(addr & WIN_MASK[i]) == WIN_BASE[i]`.
  - Lowest index wins.
  - Translated address is `(WIN_TGT[i] | (addr & ~WIN_MASK[i]))[ADDR_W_OUT-1:0]`.
- Mapped AR/AW:
  - Combinational pass-through with translated address; all other fields unchanged.
  - `s_*ready = m_*ready`, gated by the stall conditions below.
- Outstanding counters `rd_cnt` and `wr_cnt`, each `$clog2(MAX_OUT+1)` bits:
  - Increment on a forwarded AR/AW handshake.
  - Decrement on an R beat with last / a B handshake.
  - Increment and decrement in the same cycle leave the count unchanged.
- Stall conditions: AR/AW is not accepted when its counter equals `MAX_OUT` or when that direction's error FSM is not IDLE.
- Read error FSM:
  - IDLE → R_WAIT on an unmapped AR handshake (`arready=1` in IDLE). Capture id and len.
  - R_WAIT → R_RESP when `rd_cnt==0`.
  - R_RESP drives `len+1` beats on `s_r*`: `rdata=0`, `rresp=2'b11`, the captured id, `rlast` on the final beat. Each beat advances on `rvalid&rready`.
  - R_RESP → IDLE after the last beat.
  - While not IDLE, `s_r*` is muxed from the FSM and `m_rready=0`.
- Write error FSM:
  - IDLE → W_WAIT on an unmapped AW handshake; capture id.
  - W_WAIT → W_SINK when `wr_cnt==0`.
  - In W_SINK, `s_wready=1` and `m_wvalid=0`; beats are discarded until `wlast`.
  - W_SINK → B_RESP.
  - B_RESP drives `bvalid` with `bresp=2'b11` and the captured id; → IDLE on `bready`.
- W channel is otherwise forwarded unchanged.
- Same-ID ordering is preserved: error responses are issued only after all earlier forwarded transactions in that direction have completed.
- AR and AW are independent and may be in error simultaneously.

## Timing
- Mapped path latency: 0 cycles, purely combinational.
- Earliest error R beat: cycle after the AR handshake, when `rd_cnt==0`.
- Earliest `bvalid`: cycle after the `wlast` handshake.
- Error-path outputs are registered; once valid is asserted, payloads are held stable until the handshake.
- Reset values:
  - FSMs IDLE; counters 0.
  - All FSM-driven valids 0; `s_wready` from the FSM is 0.
  - `err_val=0`, `err_addr=0`, `err_cnt=0`.
- Reset mid-burst: the FSM returns to IDLE immediately and the partial response is abandoned.

## Configuration
- `HYDRA_REMAP_ERR_LOG_EN` defined:
  - `err_val`, `err_addr`, `err_cnt` are live.
  - If AR and AW both fault in the same cycle, the AR address is logged and `err_cnt` increments by 2.
- Undefined: the three outputs are tied to 0 and no log registers exist.

## Structure
- Shared package `hydra_remap_pkg`:
  - FSM state enums `rd_err_e`, `wr_err_e`.
  - `AXI_RESP_DECERR=2'b11`.
  - Function `win_hit` returning the hit vector.
- One sub-module is natural: `hydra_remap_dec`, the combinational window decoder, instantiated once for AR and once for AW.

## Test plan
- Defaults, AR addr `0x0000_0000_8000_1000` → `m_araddr=0x8000_1000`; data is returned unchanged with OKAY.
- `NUM_WIN=2`, window 1 with base `0x1_0000_0000`, mask `0xFFFF_FFFF_F000_0000`, tgt `0x4000_0000`; AW `0x1_0000_0040` → `m_awaddr=0x4000_0040`.
- Unmapped AR `0xF_0000_0000`, len=3, id=5 → 4 R beats, `rresp=3`, `rid=5`, `rlast` on beat 4; `err_cnt=1`.
- Unmapped AW len=1 issued while 2 forwarded writes are outstanding → W beats sunk; `bvalid` only after both downstream B handshakes; `bresp=3`.
- Issue `MAX_OUT` forwarded ARs with `m_rvalid` held low → the next AR sees `s_arready=0`.
- Assert `arst_n` low mid error burst → `s_rvalid=0` the same cycle; FSM IDLE after release.
